// File: rtl/pce_capture_pkg.sv
// rtl/pce_capture_pkg.sv - shared types, FSM states and CRC helper for the PCE frame capture block
package pce_capture_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSKIP = 3'd1,
    S_HSKIP = 3'd2,
    S_CAPT  = 3'd3,
    S_HWAIT = 3'd4
  } capt_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One pixel zero-extended to 16 bits, shifted in MSB first.
  function automatic logic [15:0] crc16_pixel(input logic [15:0] crc, input rgb333_t px);
    logic [15:0] c;
    logic [15:0] w;
    c = crc;
    w = {7'b0, px};
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ w[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - synchronous FIFO with full/empty flags for framebuffer writes
module capture_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_accept
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign w_rd     = i_pop & ~o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_wr     = i_push & (~o_full | w_rd);
  assign o_accept = w_wr;
  assign o_data   = r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pce_frame_capture.sv
// rtl/pce_frame_capture.sv - crops the VCE RGB333 stream into framebuffer writes
// Optional frame CRC output enabled by macro PCE_CAPTURE_CRC_EN.
module pce_frame_capture
  import pce_capture_pkg::*;
#(
  parameter int H_START    = 64,
  parameter int H_ACTIVE   = 256,
  parameter int V_START    = 20,
  parameter int V_ACTIVE   = 240,
  parameter int FB_STRIDE  = 256,
  parameter int FB_AW      = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_en,
  input  logic [2:0]       VIDEO_R,
  input  logic [2:0]       VIDEO_G,
  input  logic [2:0]       VIDEO_B,
  input  logic             HSYNC_n,
  input  logic             VSYNC_n,
  output logic             fb_valid,
  input  logic             fb_ready,
  output logic [FB_AW-1:0] fb_addr,
  output logic [8:0]       fb_data,
  output logic             frame_done,
  output logic             frame_overflow,
  output logic             busy
`ifdef PCE_CAPTURE_CRC_EN
  ,
  output logic [15:0]      frame_crc
`endif
);

  localparam int CW = 16;
  localparam logic [CW-1:0]    LP_H_START  = CW'(H_START);
  localparam logic [CW-1:0]    LP_H_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]    LP_V_START  = CW'(V_START);
  localparam logic [CW-1:0]    LP_V_ACTIVE = CW'(V_ACTIVE);
  localparam logic [FB_AW-1:0] LP_STRIDE   = FB_AW'(FB_STRIDE);

  logic r_hs, r_hs_d, r_vs, r_vs_d;
  logic w_hfall, w_vfall;

  capt_state_t      r_state, w_state_nxt;
  logic [CW-1:0]    r_vline, w_vline_nxt;
  logic [CW-1:0]    r_hcnt, w_hcnt_nxt;
  logic [CW-1:0]    r_col, w_col_nxt;
  logic [CW-1:0]    r_line_cnt, w_line_nxt;
  logic [FB_AW-1:0] r_base_addr, w_base_nxt;
  logic             w_push;
  logic             w_frame_end;

  logic r_frame_done, r_frame_overflow, r_ovf_latch;

  rgb333_t              w_pix;
  logic [FB_AW-1:0]     w_pix_addr;
  logic [FB_AW+8:0]     w_head;
  logic                 w_full, w_empty, w_accept, w_drop;

  assign w_hfall    = r_hs_d & ~r_hs;
  assign w_vfall    = r_vs_d & ~r_vs;
  assign w_pix      = '{r: VIDEO_R, g: VIDEO_G, b: VIDEO_B};
  assign w_pix_addr = r_base_addr + FB_AW'(r_col);
  assign w_drop     = w_push & ~w_accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs   <= 1'b1;
      r_hs_d <= 1'b1;
      r_vs   <= 1'b1;
      r_vs_d <= 1'b1;
    end else begin
      r_hs   <= HSYNC_n;
      r_hs_d <= r_hs;
      r_vs   <= VSYNC_n;
      r_vs_d <= r_vs;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vline_nxt = r_vline;
    w_hcnt_nxt  = r_hcnt;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line_cnt;
    w_base_nxt  = r_base_addr;
    w_push      = 1'b0;
    w_frame_end = 1'b0;
    if (w_vfall) begin
      w_frame_end = (r_state != S_IDLE);
      w_line_nxt  = '0;
      w_base_nxt  = '0;
      w_vline_nxt = '0;
      w_hcnt_nxt  = '0;
      w_col_nxt   = '0;
      w_state_nxt = (V_START == 0) ? S_HSKIP : S_VSKIP;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_VSKIP: begin
          if (w_hfall) begin
            w_vline_nxt = r_vline + 1'b1;
            if (r_vline + 1'b1 == LP_V_START) begin
              w_state_nxt = S_HSKIP;
              w_col_nxt   = '0;
              w_hcnt_nxt  = '0;
            end
          end
        end
        S_HSKIP, S_CAPT, S_HWAIT: begin
          if (w_hfall) begin
            // Once the window is complete, further lines are ignored until vfall.
            if (r_line_cnt != LP_V_ACTIVE) begin
              w_line_nxt  = r_line_cnt + 1'b1;
              w_base_nxt  = r_base_addr + LP_STRIDE;
              w_col_nxt   = '0;
              w_hcnt_nxt  = '0;
              w_state_nxt = (r_line_cnt + 1'b1 == LP_V_ACTIVE) ? S_HWAIT : S_HSKIP;
            end
          end else if (clock_en) begin
            if (r_state == S_CAPT || (r_state == S_HSKIP && H_START == 0)) begin
              w_push      = 1'b1;
              w_col_nxt   = r_col + 1'b1;
              w_state_nxt = (r_col == LP_H_LAST) ? S_HWAIT : S_CAPT;
            end else if (r_state == S_HSKIP) begin
              w_hcnt_nxt = r_hcnt + 1'b1;
              if (r_hcnt + 1'b1 == LP_H_START) w_state_nxt = S_CAPT;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_vline          <= '0;
      r_hcnt           <= '0;
      r_col            <= '0;
      r_line_cnt       <= '0;
      r_base_addr      <= '0;
      r_frame_done     <= 1'b0;
      r_frame_overflow <= 1'b0;
      r_ovf_latch      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vline      <= w_vline_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_col        <= w_col_nxt;
      r_line_cnt   <= w_line_nxt;
      r_base_addr  <= w_base_nxt;
      r_frame_done <= w_frame_end;
      // Pushes never happen on a vfall cycle, so no drop can race the latch clear.
      if (w_frame_end) begin
        r_frame_overflow <= r_ovf_latch;
        r_ovf_latch      <= 1'b0;
      end else if (w_drop) begin
        r_ovf_latch <= 1'b1;
      end
    end
  end

  capture_fifo #(
    .WIDTH (FB_AW + 9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .i_push   (w_push),
    .i_data   ({w_pix_addr, w_pix}),
    .i_pop    (fb_ready),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_accept (w_accept)
  );

  assign fb_valid       = ~w_empty;
  assign fb_addr        = fb_valid ? w_head[FB_AW+8:9] : '0;
  assign fb_data        = fb_valid ? w_head[8:0] : '0;
  assign frame_done     = r_frame_done;
  assign frame_overflow = r_frame_overflow;
  assign busy           = (r_state != S_IDLE);

`ifdef PCE_CAPTURE_CRC_EN
  logic [15:0] r_crc_acc;
  logic [15:0] r_frame_crc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_crc_acc   <= CRC16_INIT;
      r_frame_crc <= '0;
    end else if (w_frame_end) begin
      r_frame_crc <= r_crc_acc;
      r_crc_acc   <= CRC16_INIT;
    end else if (w_accept) begin
      r_crc_acc <= crc16_pixel(r_crc_acc, w_pix);
    end
  end

  assign frame_crc = r_frame_crc;
`endif

endmodule

// File: tb/tb_pce_frame_capture.sv
// tb/tb_pce_frame_capture.sv - directed self-checking bench for pce_frame_capture
module tb_pce_frame_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_en;
  logic [2:0]  VIDEO_R, VIDEO_G, VIDEO_B;
  logic        HSYNC_n, VSYNC_n;
  logic        fb_valid, fb_ready;
  logic [16:0] fb_addr;
  logic [8:0]  fb_data;
  logic        frame_done, frame_overflow, busy;
`ifdef PCE_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
  logic [15:0] last_crc;
`endif

  pce_frame_capture #(
    .H_START(2), .H_ACTIVE(4), .V_START(1), .V_ACTIVE(2),
    .FB_STRIDE(8), .FB_AW(17), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .frame_overflow(frame_overflow), .busy(busy)
`ifdef PCE_CAPTURE_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [16:0] addr; logic [8:0] data; } wr_t;
  typedef struct { int line; int pix; logic [16:0] addr; logic [8:0] data; } vec_t;

  wr_t  wq[$];
  vec_t tbl[8];
  int   fd_cnt;
  logic last_ovf;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge clock) begin
    if (fb_valid && fb_ready) wq.push_back('{addr: fb_addr, data: fb_data});
    if (frame_done) begin
      fd_cnt++;
      last_ovf = frame_overflow;
`ifdef PCE_CAPTURE_CRC_EN
      last_crc = frame_crc;
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_write(input string name, input int idx, input logic [16:0] a, input logic [8:0] d);
    if (idx < wq.size())
      check($sformatf("%s[%0d]", name, idx), 32'({wq[idx].addr, wq[idx].data}), 32'({a, d}));
    else begin
      n_checks++;
      $display("FAIL %s[%0d]: write missing, expected addr %0h data %0h", name, idx, a, d);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    fd_cnt = 0;
  endtask

  task automatic vsync();
    VSYNC_n = 1'b0;
    repeat (2) tick();
    VSYNC_n = 1'b1;
    repeat (4) tick();
  endtask

  // Pixel value encodes frame/line/position unless solid, which sends 0x1FF.
  task automatic line(input int fid, input int lid, input int npix, input bit solid);
    logic [8:0] v;
    HSYNC_n = 1'b0;
    repeat (2) tick();
    HSYNC_n = 1'b1;
    repeat (3) tick();
    for (int p = 0; p < npix; p++) begin
      v = solid ? 9'h1FF : 9'((fid % 4) * 128 + lid * 16 + p);
      {VIDEO_R, VIDEO_G, VIDEO_B} = v;
      clock_en = 1'b1;
      tick();
    end
    clock_en = 1'b0;
    repeat (2) tick();
  endtask

`ifdef PCE_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [8:0] d);
    logic [15:0] r;
    logic [15:0] w;
    r = c;
    w = {7'b0, d};
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ w[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction
`endif

  initial begin
    int sel[6];
`ifdef PCE_CAPTURE_CRC_EN
    logic [15:0] m4, m8, c_p, c_q;
`endif
    tbl[0] = '{0, 2, 17'd0,  9'h002};
    tbl[1] = '{0, 3, 17'd1,  9'h003};
    tbl[2] = '{0, 4, 17'd2,  9'h004};
    tbl[3] = '{0, 5, 17'd3,  9'h005};
    tbl[4] = '{1, 2, 17'd8,  9'h012};
    tbl[5] = '{1, 3, 17'd9,  9'h013};
    tbl[6] = '{1, 4, 17'd10, 9'h014};
    tbl[7] = '{1, 5, 17'd11, 9'h015};
    sel = '{0, 1, 4, 5, 6, 7};

    reset = 1'b1; clock_en = 1'b0; fb_ready = 1'b1;
    HSYNC_n = 1'b1; VSYNC_n = 1'b1;
    {VIDEO_R, VIDEO_G, VIDEO_B} = 9'h0;
    fd_cnt = 0; last_ovf = 1'b0;
    repeat (3) tick();
    check("rst_fb_valid", 32'(fb_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overflow", 32'(frame_overflow), 0);
    check("rst_fb_addr_data", 32'({fb_addr, fb_data}), 0);
`ifdef PCE_CAPTURE_CRC_EN
    check("rst_frame_crc", 32'(frame_crc), 0);
`endif
    reset = 1'b0;
    tick();

    // Capture window
    clear_mon();
    vsync();
    check("first_vsync_no_done", 32'(fd_cnt), 0);
    check("busy_after_vsync", 32'(busy), 1);
    for (int l = 0; l < 4; l++) line(0, l, 8, 1'b0);
    vsync();
    check("win_done_cnt", 32'(fd_cnt), 1);
    check("win_overflow", 32'(last_ovf), 0);
    check("win_write_cnt", 32'(wq.size()), 8);
    for (int i = 0; i < 8; i++) check_write("win", i, tbl[i].addr, tbl[i].data);

    // Backpressure: frame 1 fills the FIFO, frame 2 is dropped entirely
    fb_ready = 1'b0;
    clear_mon();
    line(1, 0, 8, 1'b0); line(1, 1, 8, 1'b0);
    vsync();
    check("bp_fill_done", 32'(fd_cnt), 1);
    check("bp_fill_overflow", 32'(last_ovf), 0);
    check("bp_head", 32'({fb_valid, fb_addr, fb_data}), 32'({1'b1, 17'd0, 9'h082}));
    clear_mon();
    line(2, 0, 8, 1'b0); line(2, 1, 8, 1'b0);
    check("bp_head_stable", 32'({fb_valid, fb_addr, fb_data}), 32'({1'b1, 17'd0, 9'h082}));
    vsync();
    check("bp_drop_done", 32'(fd_cnt), 1);
    check("bp_drop_overflow", 32'(last_ovf), 1);
    fb_ready = 1'b1;
    repeat (12) tick();
    check("bp_drain_cnt", 32'(wq.size()), 8);
    for (int i = 0; i < 8; i++) check_write("bp_drain", i, tbl[i].addr, 9'(tbl[i].data + 9'h080));
    clear_mon();
    line(2, 0, 8, 1'b0); line(2, 1, 8, 1'b0);
    vsync();
    check("bp_recover_overflow", 32'(last_ovf), 0);
    check("bp_recover_cnt", 32'(wq.size()), 8);

    // Short line: 2 of 4 pixels captured, next line still at base 8
    clear_mon();
    line(0, 0, 4, 1'b0); line(0, 1, 8, 1'b0); line(0, 2, 8, 1'b0);
    vsync();
    check("short_cnt", 32'(wq.size()), 6);
    for (int i = 0; i < 6; i++) check_write("short", i, tbl[sel[i]].addr, tbl[sel[i]].data);
    check("short_overflow", 32'(last_ovf), 0);

    // Simultaneous hfall and vfall mid-capture
    clear_mon();
    line(0, 0, 3, 1'b0);
    HSYNC_n = 1'b0; VSYNC_n = 1'b0;
    repeat (2) tick();
    HSYNC_n = 1'b1; VSYNC_n = 1'b1;
    repeat (4) tick();
    check("sim_done_pulse", 32'(fd_cnt), 1);
    check("sim_busy", 32'(busy), 1);
    line(1, 0, 8, 1'b0);
    check("sim_cnt", 32'(wq.size()), 5);
    check_write("sim", 0, 17'd0, 9'h002);
    check_write("sim", 1, 17'd0, 9'h082);
    check_write("sim", 4, 17'd3, 9'h085);

    // Reset mid-line with 3 entries queued
    fb_ready = 1'b0;
    vsync();
    clear_mon();
    line(2, 0, 5, 1'b0);
    check("mid_valid", 32'(fb_valid), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_state", 32'({fb_valid, busy, frame_done}), 0);
    reset = 1'b0;
    fb_ready = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_writes", 32'(wq.size()), 0);
    vsync();
    check("mid_rst_no_done", 32'(fd_cnt), 0);
    line(3, 0, 8, 1'b0); line(3, 1, 8, 1'b0);
    vsync();
    check("mid_resume_cnt", 32'(wq.size()), 8);
    check_write("mid_resume", 0, 17'd0, 9'h182);
    check_write("mid_resume", 4, 17'd8, 9'h192);
    check("mid_resume_done", 32'({fd_cnt[3:0], last_ovf}), 32'({4'd1, 1'b0}));

`ifdef PCE_CAPTURE_CRC_EN
    m4 = 16'hFFFF;
    for (int i = 0; i < 4; i++) m4 = crc_model(m4, 9'h1FF);
    m8 = m4;
    for (int i = 0; i < 4; i++) m8 = crc_model(m8, 9'h1FF);
    line(0, 0, 8, 1'b1); line(0, 1, 2, 1'b1);
    vsync();
    check("crc_4px", 32'(last_crc), 32'(m4));
    line(0, 0, 8, 1'b1);
    fb_ready = 1'b0;
    line(0, 1, 8, 1'b1);
    vsync();
    c_p = last_crc;
    check("crc_8px", 32'(c_p), 32'(m8));
    line(0, 0, 8, 1'b1); line(0, 1, 8, 1'b1);
    vsync();
    c_q = last_crc;
    check("crc_drop_overflow", 32'(last_ovf), 1);
    check("crc_drop_val", 32'(c_q), 32'(m4));
    check("crc_drop_differs", 32'(c_q != c_p), 1);
    fb_ready = 1'b1;
    repeat (12) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
